// File: rtl/kirby_anim_if.sv
// kirby_anim_if: frame-tick control inputs and the per-frame sprite
// parameters that are handed to the ray-march renderer.
interface kirby_anim_if;
  logic       frame_tick;
  logic       enable;
  logic [9:0] center_x;
  logic [9:0] center_y;
  logic [3:0] squash;
  logic       facing;
  logic       eye_open;
  logic [7:0] frame_count;
  logic       params_updated;

  // Timing/control side: drives the tick and enable, consumes parameters.
  modport master (
    output frame_tick,
    output enable,
    input  center_x,
    input  center_y,
    input  squash,
    input  facing,
    input  eye_open,
    input  frame_count,
    input  params_updated
  );

  // Sequencer side: consumes the tick and enable, produces parameters.
  modport slave (
    input  frame_tick,
    input  enable,
    output center_x,
    output center_y,
    output squash,
    output facing,
    output eye_open,
    output frame_count,
    output params_updated
  );
endinterface

// File: rtl/kirby_anim_ctrl.sv
// kirby_anim_ctrl: per-frame animation sequencer for the Kirby renderer.
// Every piece of state moves only on the frame_tick edge (start of vblank),
// so the renderer always sees one consistent parameter set per frame.
module kirby_anim_ctrl #(
  parameter int         BASE_X        = 320,
  parameter int         BASE_Y        = 240,
  parameter int         X_RANGE       = 64,
  parameter int         LAUNCH_V      = 9,
  parameter int         SQUASH_FRAMES = 4,
  parameter int         BLINK_MIN     = 64,
  parameter int         BLINK_LEN     = 6,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input logic         clk,
  input logic         rst,
  kirby_anim_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_AIR    = 2'd1,
    ST_SQUASH = 2'd2
  } bounce_e;

  typedef enum logic {
    BL_OPEN   = 1'b0,
    BL_CLOSED = 1'b1
  } blink_e;

  localparam logic signed [5:0] VY_LAUNCH  = 6'(-LAUNCH_V);
  localparam logic signed [8:0] X_HI       = 9'(X_RANGE);
  localparam logic signed [8:0] X_LO       = 9'(-X_RANGE);
  localparam logic [3:0]        SQ_INIT    = 4'(SQUASH_FRAMES);
  localparam logic [7:0]        OPEN_MIN   = 8'(BLINK_MIN);
  localparam logic [7:0]        CLOSED_TOP = 8'(BLINK_LEN - 1);

  // Sprite centre from a signed horizontal offset.
  function automatic logic [9:0] f_center_x(input logic signed [8:0] off);
    return 10'(BASE_X) + {off[8], off};
  endfunction

  // Sprite centre from a signed (never positive) vertical offset.
  function automatic logic [9:0] f_center_y(input logic signed [7:0] off);
    return 10'(BASE_Y) + {{2{off[7]}}, off};
  endfunction

  // One step of the blink randomiser.
  function automatic logic [7:0] f_lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  bounce_e            r_state,   w_state_nxt;
  logic signed [7:0]  r_y_off,   w_y_off_nxt;
  logic signed [5:0]  r_vy,      w_vy_nxt;
  logic [3:0]         r_sq_cnt,  w_sq_cnt_nxt;
  logic [3:0]         r_squash,  w_squash_nxt;
  logic signed [8:0]  r_x_off,   w_x_off_nxt;
  logic               r_facing,  w_facing_nxt;
  blink_e             r_blink,   w_blink_nxt;
  logic [7:0]         r_timer,   w_timer_nxt;
  logic [7:0]         r_lfsr,    w_lfsr_nxt;
  logic [7:0]         r_frame_cnt;
  logic               r_tick_d;
  logic               r_params_upd;
  logic [9:0]         r_center_x;
  logic [9:0]         r_center_y;
  logic               w_advance;
  logic signed [8:0]  w_land_sum;

  assign w_advance  = bus.frame_tick & bus.enable;
  assign w_land_sum = {r_y_off[7], r_y_off} + {{3{r_vy[5]}}, r_vy};

  // Next-state logic for bounce FSM, drift and blink; holds unless advancing.
  always_comb begin
    w_state_nxt  = r_state;
    w_y_off_nxt  = r_y_off;
    w_vy_nxt     = r_vy;
    w_sq_cnt_nxt = r_sq_cnt;
    w_squash_nxt = r_squash;
    w_x_off_nxt  = r_x_off;
    w_facing_nxt = r_facing;
    w_blink_nxt  = r_blink;
    w_timer_nxt  = r_timer;
    w_lfsr_nxt   = r_lfsr;

    if (w_advance) begin
      unique case (r_state)
        ST_IDLE: begin
          w_vy_nxt    = VY_LAUNCH;
          w_state_nxt = ST_AIR;
        end
        ST_AIR: begin
          if (!w_land_sum[8]) begin
            w_y_off_nxt  = 8'sd0;
            w_vy_nxt     = 6'sd0;
            w_squash_nxt = SQ_INIT;
            w_sq_cnt_nxt = SQ_INIT;
            w_state_nxt  = ST_SQUASH;
          end else begin
            w_y_off_nxt = w_land_sum[7:0];
            w_vy_nxt    = r_vy + 6'sd1;
          end
        end
        ST_SQUASH: begin
          if (r_sq_cnt == 4'd1) begin
            w_squash_nxt = 4'd0;
            w_vy_nxt     = VY_LAUNCH;
            w_state_nxt  = ST_AIR;
          end else begin
            w_sq_cnt_nxt = r_sq_cnt - 4'd1;
            w_squash_nxt = r_sq_cnt - 4'd1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase

      // Flip and step share the tick, so the turnaround never pauses.
      if (r_facing && (r_x_off == X_HI)) begin
        w_facing_nxt = 1'b0;
        w_x_off_nxt  = r_x_off - 9'sd1;
      end else if (!r_facing && (r_x_off == X_LO)) begin
        w_facing_nxt = 1'b1;
        w_x_off_nxt  = r_x_off + 9'sd1;
      end else if (r_facing) begin
        w_x_off_nxt  = r_x_off + 9'sd1;
      end else begin
        w_x_off_nxt  = r_x_off - 9'sd1;
      end

      // The open interval reload draws on the LFSR value before this shift.
      unique case (r_blink)
        BL_OPEN: begin
          if (r_timer == 8'd0) begin
            w_blink_nxt = BL_CLOSED;
            w_timer_nxt = CLOSED_TOP;
          end else begin
            w_timer_nxt = r_timer - 8'd1;
          end
        end
        BL_CLOSED: begin
          if (r_timer == 8'd0) begin
            w_blink_nxt = BL_OPEN;
            w_timer_nxt = OPEN_MIN + {2'b00, r_lfsr[5:0]};
          end else begin
            w_timer_nxt = r_timer - 8'd1;
          end
        end
        default: w_blink_nxt = BL_OPEN;
      endcase

      w_lfsr_nxt = f_lfsr_step(r_lfsr);
    end
  end

  // State and output registers; the update pulse trails the tick by one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_y_off      <= 8'sd0;
      r_vy         <= 6'sd0;
      r_sq_cnt     <= 4'd0;
      r_squash     <= 4'd0;
      r_x_off      <= 9'sd0;
      r_facing     <= 1'b1;
      r_blink      <= BL_OPEN;
      r_timer      <= OPEN_MIN;
      r_lfsr       <= LFSR_SEED;
      r_frame_cnt  <= 8'd0;
      r_tick_d     <= 1'b0;
      r_params_upd <= 1'b0;
      r_center_x   <= 10'(BASE_X);
      r_center_y   <= 10'(BASE_Y);
    end else begin
      r_state      <= w_state_nxt;
      r_y_off      <= w_y_off_nxt;
      r_vy         <= w_vy_nxt;
      r_sq_cnt     <= w_sq_cnt_nxt;
      r_squash     <= w_squash_nxt;
      r_x_off      <= w_x_off_nxt;
      r_facing     <= w_facing_nxt;
      r_blink      <= w_blink_nxt;
      r_timer      <= w_timer_nxt;
      r_lfsr       <= w_lfsr_nxt;
      r_center_x   <= f_center_x(w_x_off_nxt);
      r_center_y   <= f_center_y(w_y_off_nxt);
      r_tick_d     <= bus.frame_tick;
      r_params_upd <= r_tick_d;
      if (bus.frame_tick) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  assign bus.center_x       = r_center_x;
  assign bus.center_y       = r_center_y;
  assign bus.squash         = r_squash;
  assign bus.facing         = r_facing;
  assign bus.eye_open       = (r_blink == BL_OPEN);
  assign bus.frame_count    = r_frame_cnt;
  assign bus.params_updated = r_params_upd;

endmodule

// File: tb/tb_kirby_anim_ctrl.sv
// tb_kirby_anim_ctrl: directed bench for the animation sequencer with a
// reference model feeding an expected-parameter queue, drained on each
// params_updated pulse.
module tb_kirby_anim_ctrl;

  localparam int LV   = 3;
  localparam int SQF  = 2;
  localparam int XR   = 2;
  localparam int BMIN = 4;
  localparam int BLEN = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  kirby_anim_if bus_if ();

  kirby_anim_ctrl #(
    .BASE_X       (320),
    .BASE_Y       (240),
    .X_RANGE      (XR),
    .LAUNCH_V     (LV),
    .SQUASH_FRAMES(SQF),
    .BLINK_MIN    (BMIN),
    .BLINK_LEN    (BLEN),
    .LFSR_SEED    (8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  typedef struct packed {
    logic [9:0] cx;
    logic [9:0] cy;
    logic [3:0] sq;
    logic       fa;
    logic       eye;
    logic [7:0] fc;
  } snap_t;

  snap_t exp_q[$];
  snap_t prev_snap;

  int n_assert = 0;
  int n_fail   = 0;
  int n_pulse  = 0;

  // Reference model state
  int         m_xoff, m_yoff, m_vy, m_state, m_sqcnt, m_squash;
  int         m_facing, m_blink, m_timer, m_fc;
  logic [7:0] m_lfsr;

  // Expected values after ticks 1..N from reset
  int cy_tab[11]  = '{240, 237, 235, 234, 234, 235, 237, 240, 240, 240, 237};
  int sq_tab[11]  = '{0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0};
  int cx_tab[8]   = '{321, 322, 321, 320, 319, 318, 319, 320};
  int fa_tab[8]   = '{1, 1, 0, 0, 0, 0, 1, 1};
  int eye_tab[7]  = '{1, 1, 1, 1, 0, 0, 1};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic snap_t cur_snap();
    snap_t s;
    s.cx  = bus_if.center_x;
    s.cy  = bus_if.center_y;
    s.sq  = bus_if.squash;
    s.fa  = bus_if.facing;
    s.eye = bus_if.eye_open;
    s.fc  = bus_if.frame_count;
    return s;
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.cx  = 10'(320 + m_xoff);
    s.cy  = 10'(240 + m_yoff);
    s.sq  = 4'(m_squash);
    s.fa  = (m_facing != 0);
    s.eye = (m_blink == 0);
    s.fc  = 8'(m_fc);
    return s;
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  task automatic model_reset();
    m_xoff = 0; m_yoff = 0; m_vy = 0; m_state = 0; m_sqcnt = 0; m_squash = 0;
    m_facing = 1; m_blink = 0; m_timer = BMIN; m_fc = 0; m_lfsr = 8'hA5;
  endtask

  task automatic model_tick(input bit en);
    int s;
    m_fc = (m_fc + 1) % 256;
    if (!en) return;
    case (m_state)
      0: begin m_vy = -LV; m_state = 1; end
      1: begin
        s = m_yoff + m_vy;
        if (s >= 0) begin
          m_yoff = 0; m_vy = 0; m_squash = SQF; m_sqcnt = SQF; m_state = 2;
        end else begin
          m_yoff = s; m_vy = m_vy + 1;
        end
      end
      default: begin
        if (m_sqcnt == 1) begin
          m_squash = 0; m_vy = -LV; m_state = 1;
        end else begin
          m_sqcnt = m_sqcnt - 1; m_squash = m_sqcnt;
        end
      end
    endcase
    if (m_facing == 1 && m_xoff == XR) begin
      m_facing = 0; m_xoff = m_xoff - 1;
    end else if (m_facing == 0 && m_xoff == -XR) begin
      m_facing = 1; m_xoff = m_xoff + 1;
    end else begin
      m_xoff = m_xoff + ((m_facing == 1) ? 1 : -1);
    end
    if (m_blink == 0) begin
      if (m_timer == 0) begin m_blink = 1; m_timer = BLEN - 1; end
      else m_timer = m_timer - 1;
    end else begin
      if (m_timer == 0) begin m_blink = 0; m_timer = BMIN + int'(m_lfsr[5:0]); end
      else m_timer = m_timer - 1;
    end
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  // Advance to the next falling edge and score any update pulse seen there.
  task automatic cyc();
    snap_t e;
    @(negedge clk);
    if (bus_if.params_updated === 1'b1) begin
      n_pulse++;
      if (exp_q.size() == 0) begin
        chk("pu_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("scoreboard", 64'(prev_snap), 64'(e));
      end
    end
    prev_snap = cur_snap();
  endtask

  task automatic do_tick(input bit en);
    bus_if.frame_tick = 1'b1;
    bus_if.enable     = en;
    model_tick(en);
    exp_q.push_back(model_snap());
    cyc();
    bus_if.frame_tick = 1'b0;
  endtask

  task automatic tick_gap(input bit en);
    do_tick(en);
    cyc();
    cyc();
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) cyc();
    chk("sb_drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [7:0] ref_l;
    int         reload;
    int         p0;
    logic [9:0] sv_cx, sv_cy;
    logic       sv_eye;
    logic [7:0] sv_fc;

    rst = 1'b1;
    bus_if.frame_tick = 1'b0;
    bus_if.enable     = 1'b1;
    model_reset();
    repeat (3) cyc();
    rst = 1'b0;
    chk("rst_center_x", 64'(bus_if.center_x), 64'd320);
    chk("rst_center_y", 64'(bus_if.center_y), 64'd240);
    chk("rst_squash", 64'(bus_if.squash), 64'd0);
    chk("rst_facing", 64'(bus_if.facing), 64'd1);
    chk("rst_eye_open", 64'(bus_if.eye_open), 64'd1);
    chk("rst_frame_count", 64'(bus_if.frame_count), 64'd0);
    chk("rst_params_updated", 64'(bus_if.params_updated), 64'd0);

    ref_l = 8'hA5;
    for (int i = 0; i < 6; i++) ref_l = lfsr_next(ref_l);
    reload = BMIN + int'(ref_l[5:0]);

    for (int k = 1; k <= reload + 8; k++) begin
      tick_gap(1'b1);
      if (k <= 11) begin
        chk($sformatf("bounce_cy_t%0d", k), 64'(bus_if.center_y), 64'(cy_tab[k-1]));
        chk($sformatf("bounce_sq_t%0d", k), 64'(bus_if.squash), 64'(sq_tab[k-1]));
      end
      if (k <= 8) begin
        chk($sformatf("drift_cx_t%0d", k), 64'(bus_if.center_x), 64'(cx_tab[k-1]));
        chk($sformatf("drift_facing_t%0d", k), 64'(bus_if.facing), 64'(fa_tab[k-1]));
      end
      if (k <= 7)
        chk($sformatf("blink_eye_t%0d", k), 64'(bus_if.eye_open), 64'(eye_tab[k-1]));
      else if (k <= reload + 7)
        chk($sformatf("blink_hold_open_t%0d", k), 64'(bus_if.eye_open), 64'd1);
      else
        chk($sformatf("blink_reclose_t%0d", k), 64'(bus_if.eye_open), 64'd0);
    end

    p0 = n_pulse;
    repeat (5) do_tick(1'b1);
    drain();
    chk("b2b_pulse_count", 64'(n_pulse - p0), 64'd5);

    sv_cx = bus_if.center_x; sv_cy = bus_if.center_y;
    sv_eye = bus_if.eye_open; sv_fc = bus_if.frame_count;
    p0 = n_pulse;
    repeat (10) tick_gap(1'b0);
    chk("dis_frame_count", 64'(bus_if.frame_count), 64'(8'(sv_fc + 8'd10)));
    chk("dis_center_x", 64'(bus_if.center_x), 64'(sv_cx));
    chk("dis_center_y", 64'(bus_if.center_y), 64'(sv_cy));
    chk("dis_eye_open", 64'(bus_if.eye_open), 64'(sv_eye));
    chk("dis_pulse_count", 64'(n_pulse - p0), 64'd10);
    repeat (3) tick_gap(1'b1);
    chk("resume_x_moved", 64'(bus_if.center_x != sv_cx), 64'd1);

    for (int i = 0; i < 40 && !(m_state == 1 && m_yoff < 0); i++) tick_gap(1'b1);
    chk("mid_air_before_rst", 64'(bus_if.center_y < 10'd240), 64'd1);
    drain();
    rst = 1'b1;
    cyc();
    chk("rst_edge_center_y", 64'(bus_if.center_y), 64'd240);
    cyc();
    cyc();
    rst = 1'b0;
    model_reset();
    chk("rst2_center_x", 64'(bus_if.center_x), 64'd320);
    chk("rst2_squash", 64'(bus_if.squash), 64'd0);
    chk("rst2_facing", 64'(bus_if.facing), 64'd1);
    chk("rst2_frame_count", 64'(bus_if.frame_count), 64'd0);
    tick_gap(1'b1);
    chk("rst2_first_tick_cy", 64'(bus_if.center_y), 64'd240);
    tick_gap(1'b1);
    chk("rst2_second_tick_cy", 64'(bus_if.center_y), 64'd237);

    for (int i = 0; i < 253; i++) begin
      do_tick(1'b1);
      cyc();
    end
    chk("fc_before_wrap", 64'(bus_if.frame_count), 64'd255);
    tick_gap(1'b1);
    chk("fc_wrap", 64'(bus_if.frame_count), 64'd0);

    tick_gap(1'b1);
    drain();
    p0 = n_pulse;
    rst = 1'b1;
    bus_if.frame_tick = 1'b1;
    cyc();
    rst = 1'b0;
    bus_if.frame_tick = 1'b0;
    model_reset();
    repeat (3) cyc();
    chk("tick_in_rst_fc", 64'(bus_if.frame_count), 64'd0);
    chk("tick_in_rst_cx", 64'(bus_if.center_x), 64'd320);
    chk("tick_in_rst_no_pulse", 64'(n_pulse - p0), 64'd0);

    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/kirby_anim_ctrl.md
Name: kirby_anim_ctrl

Overview:
- Per-frame animation sequencer that sits directly upstream of the Kirby ray-march renderer.
- Advances once per video frame on a vertical-blank tick from the VGA timing generator.
- Produces the sprite's position, bounce squash, blink state and frame counter as stable registered parameters.
- Outputs change only during blanking, so the renderer never sees a parameter change mid-frame (no tearing).

Parameters:
- BASE_X, 320: resting sprite centre, x (pixels).
- BASE_Y, 240: resting sprite centre, y (pixels, ground line).
- X_RANGE, 64: horizontal drift half-range in pixels (1..255).
- LAUNCH_V, 9: launch speed in px/frame (1..15); peak height is LAUNCH_V*(LAUNCH_V+1)/2.
- SQUASH_FRAMES, 4: frames spent squashed on landing (1..15).
- BLINK_MIN, 64: minimum open-eye interval in frames; BLINK_MIN+63 must be <= 255.
- BLINK_LEN, 6: frames with eyes closed (1..255).
- LFSR_SEED, 8'hA5: blink LFSR reset value; must be non-zero.

Ports:
- clk, input, 1: pixel clock.
- rst, input, 1: reset, synchronous, active-high.
- frame_tick, input, 1: one-cycle pulse at start of vertical blank.
- enable, input, 1: when 0, motion and blink freeze; the frame counter still runs.
- center_x, output, 10: sprite centre x = BASE_X + x_off.
- center_y, output, 10: sprite centre y = BASE_Y + y_off (y_off <= 0).
- squash, output, 4: squash amount; 0 means none.
- facing, output, 1: 1 = moving right, 0 = moving left.
- eye_open, output, 1: 0 while blinking.
- frame_count, output, 8: frames since reset, wraps 255 -> 0.
- params_updated, output, 1: one-cycle pulse, high the cycle after outputs change.

Behaviour:
- Reset (rst high at a clk edge), taking effect on that edge, including mid-sequence:
  - Outputs: center_x=BASE_X, center_y=BASE_Y, squash=0, facing=1, eye_open=1, frame_count=0, params_updated=0.
  - Internal state: x_off=0, y_off=0, vy=0, state IDLE, blink phase OPEN, blink_timer=BLINK_MIN, lfsr=LFSR_SEED.
  - frame_tick is ignored while rst is high.
- Latency: all state and outputs update on the clk edge where frame_tick=1. params_updated goes high on the next edge for exactly one cycle. Back-to-back ticks are each processed.
- Per tick, always: frame_count+1 (mod 256).
- Per tick with enable=1, all of the following happen in the same edge.
- Bounce FSM (vy signed 6-bit; y_off signed 8-bit):
  - IDLE: vy<=-LAUNCH_V; go to AIR. y_off unchanged.
  - AIR, with s = y_off+vy:
    - if s >= 0: y_off<=0, vy<=0, squash<=SQUASH_FRAMES, sq_cnt<=SQUASH_FRAMES, go to SQUASH.
    - else: y_off<=s, vy<=vy+1.
  - SQUASH:
    - if sq_cnt==1: squash<=0, vy<=-LAUNCH_V, go to AIR.
    - else: sq_cnt-1, squash<=sq_cnt-1.
- Drift (x_off signed 9-bit, 1 px per tick):
  - facing=1 and x_off==X_RANGE: facing<=0, x_off-1.
  - facing=0 and x_off==-X_RANGE: facing<=1, x_off+1.
  - otherwise x_off moves 1 px in the facing direction.
  - The direction flip and the step happen on the same tick.
- Blink (blink_timer 8-bit):
  - lfsr shifts left each enabled tick with feedback l[7]^l[5]^l[4]^l[3].
  - The reload uses the pre-shift lfsr value.
  - OPEN: if timer==0, eye_open<=0, timer<=BLINK_LEN-1, go to CLOSED; else timer-1.
  - CLOSED: if timer==0, eye_open<=1, timer<=BLINK_MIN+lfsr[5:0], go to OPEN; else timer-1.
- With enable=0: bounce, drift, blink and lfsr hold. params_updated still pulses and frame_count still advances.
- Arithmetic:
  - center_x = BASE_X + sign-extended x_off; center_y = BASE_Y + sign-extended y_off, both 10-bit.
  - Parameter ranges guarantee no overflow.

Test Plan:
- Reset: assert rst for 3 cycles mid-AIR, then release -> all outputs at reset values, and the first tick leaves center_y=240 and moves the FSM to AIR.
- Bounce, LAUNCH_V=3, SQUASH_FRAMES=2, ticks 1..11:
  - center_y after each tick = 240, 237, 235, 234, 234, 235, 237, 240, 240, 240, then 237.
  - squash after each tick = 0 (ticks 1-7), 2, 1, 0, 0.
- Drift, X_RANGE=2, 8 ticks:
  - x_off after each tick = 1, 2, 1, 0, -1, -2, -1, 0.
  - facing = 1, 1, 0, 0, 0, 0, 1, 1.
- Blink, BLINK_MIN=4, BLINK_LEN=2:
  - eye_open=0 after ticks 5 and 6, and 1 again after tick 7.
  - Timer reloads to 4 + (pre-shift lfsr[5:0]), checked against a reference LFSR seeded with 8'hA5.
- Enable low for 10 ticks, then high:
  - frame_count +10; center_x, center_y, eye_open unchanged; params_updated pulses 10 times.
  - Motion resumes from the frozen state.
- 256 ticks: frame_count wraps to 0. A frame_tick asserted coincident with rst -> no update and no params_updated pulse.
